// File: rtl/test_pattern_pkg.sv
// Shared types and default geometry for the LED-panel test pattern generator.
package test_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CATERPILLAR = 2'd0,
    MODE_DOT         = 2'd1,
    MODE_FILL        = 2'd2,
    MODE_ALL_ON      = 2'd3
  } pattern_mode_t;

  localparam int unsigned DEF_NB_COLS     = 40;
  localparam int unsigned DEF_NB_ROWS     = 48;
  localparam int unsigned DEF_STEP_CYCLES = 40960;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_TAIL_LEN    = 4;

  // Flat pixel count of one slice.
  function automatic int unsigned pixel_count(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// RAM-like pixel read port: address in, registered data out one cycle later.
interface test_pattern_gen_if #(
  parameter int unsigned DATA_W = 16
);
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_data;

  modport master (output r_addr, input  r_data);
  modport slave  (input  r_addr, output r_data);
endinterface

// File: rtl/step_timer.sv
// Animation step timer: free-running period when enabled, manual single steps when frozen.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 40960
) (
  input  logic clk,
  input  logic nrst,
  input  logic enable,
  input  logic step_req,
  input  logic clear,
  output logic advance
);

  localparam int unsigned CNT_W = $clog2(STEP_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic             wrap_c;

  assign wrap_c = (count_q == CNT_W'(STEP_CYCLES - 1));

  // step_req only matters while frozen, so a coincident wrap cannot double-step.
  assign advance = !clear && (enable ? wrap_c : step_req);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= wrap_c ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator: animated head position plus a registered per-pixel lookup.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int unsigned     NB_COLS     = DEF_NB_COLS,
  parameter int unsigned     NB_ROWS     = DEF_NB_ROWS,
  parameter int unsigned     DATA_W      = DEF_DATA_W,
  parameter int unsigned     STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned     TAIL_LEN    = DEF_TAIL_LEN,
  parameter logic [DATA_W-1:0] COLOR_ON  = {DATA_W{1'b1}}
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   enable,
  input  logic                                   step_req,
  input  pattern_mode_t                          mode,
  test_pattern_gen_if.slave                      rd,
  output logic [$clog2(NB_COLS*NB_ROWS)-1:0]     head_index,
  output logic                                   step_pulse
);

  localparam int unsigned N     = pixel_count(NB_COLS, NB_ROWS);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned D_W   = IDX_W + 1;

  pattern_mode_t    mode_q;
  logic             mode_chg_c;
  logic             advance;
  logic             head_wrap_c;
  logic             in_range_c;
  logic [IDX_W-1:0] p_idx_c;
  logic [D_W-1:0]   dist_c;
  logic             lit_c;

  assign mode_chg_c  = (mode != mode_q);
  assign head_wrap_c = (head_index == IDX_W'(N - 1));

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .step_req (step_req),
    .clear    (mode_chg_c),
    .advance  (advance)
  );

  // Head position, mode register and step pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q     <= MODE_CATERPILLAR;
      head_index <= '0;
      step_pulse <= 1'b0;
    end else begin
      mode_q     <= mode;
      step_pulse <= advance;
      if (mode_chg_c) begin
        head_index <= '0;
      end else if (advance) begin
        head_index <= head_wrap_c ? '0 : head_index + IDX_W'(1);
      end
    end
  end

  // Distance behind the head, folded across pixel 0 with one conditional add.
  always_comb begin
    in_range_c = (rd.r_addr < 32'(N));
    p_idx_c    = rd.r_addr[IDX_W-1:0];
    dist_c     = '0;
    if (p_idx_c > head_index) begin
      dist_c = D_W'(head_index) + D_W'(N) - D_W'(p_idx_c);
    end else begin
      dist_c = D_W'(head_index) - D_W'(p_idx_c);
    end
  end

  always_comb begin
    lit_c = 1'b0;
    if (in_range_c) begin
      unique case (mode_q)
        MODE_CATERPILLAR: lit_c = (dist_c < D_W'(TAIL_LEN));
        MODE_DOT:         lit_c = (p_idx_c == head_index);
        MODE_FILL:        lit_c = (p_idx_c <= head_index);
        MODE_ALL_ON:      lit_c = 1'b1;
        default:          lit_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd.r_data <= '0;
    end else begin
      rd.r_data <= lit_c ? COLOR_ON : '0;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen: directed scenarios plus random traffic
// checked against a cycle-level reference model of the pattern rules.
module tb_test_pattern_gen;
  import test_pattern_pkg::*;

  localparam int unsigned NB_COLS = 4;
  localparam int unsigned NB_ROWS = 3;
  localparam int unsigned N       = NB_COLS * NB_ROWS;
  localparam int unsigned STEP    = 8;
  localparam int unsigned TAIL    = 3;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned IDX_W   = $clog2(N);
  localparam logic [15:0] ON      = 16'hFFFF;

  logic          clk      = 1'b0;
  logic          nrst     = 1'b0;
  logic          enable   = 1'b0;
  logic          step_req = 1'b0;
  pattern_mode_t mode     = MODE_CATERPILLAR;
  logic [IDX_W-1:0] head_index;
  logic             step_pulse;

  test_pattern_gen_if #(.DATA_W(DATA_W)) rd_if ();

  test_pattern_gen #(
    .NB_COLS     (NB_COLS),
    .NB_ROWS     (NB_ROWS),
    .DATA_W      (DATA_W),
    .STEP_CYCLES (STEP),
    .TAIL_LEN    (TAIL),
    .COLOR_ON    (ON)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .step_req   (step_req),
    .mode       (mode),
    .rd         (rd_if),
    .head_index (head_index),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int            m_head;
  int            m_tmr;
  pattern_mode_t m_mode;
  logic          m_pulse;
  logic [15:0]   m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic [31:0] p, input int h, input pattern_mode_t md);
    int  pi;
    bit  lit;
    if (p >= 32'(N)) return 16'h0000;
    pi = int'(p);
    case (md)
      MODE_CATERPILLAR: lit = ((h - pi + int'(N)) % int'(N)) < int'(TAIL);
      MODE_DOT:         lit = (pi == h);
      MODE_FILL:        lit = (pi <= h);
      default:          lit = 1'b1;
    endcase
    return lit ? ON : 16'h0000;
  endfunction

  task automatic model_reset();
    m_head  = 0;
    m_tmr   = 0;
    m_mode  = MODE_CATERPILLAR;
    m_pulse = 1'b0;
    m_rd    = 16'h0000;
  endtask

  // One clock: advance the model from the inputs, then compare all outputs.
  task automatic tick();
    logic [15:0] rd_next;
    bit          adv;
    rd_next = exp_pix(rd_if.r_addr, m_head, m_mode);
    adv     = 1'b0;
    if (mode != m_mode) begin
      m_mode = mode;
      m_head = 0;
      m_tmr  = 0;
    end else begin
      if (enable) begin
        adv   = (m_tmr == int'(STEP) - 1);
        m_tmr = (m_tmr + 1) % int'(STEP);
      end else begin
        adv = step_req;
      end
      if (adv) m_head = (m_head + 1) % int'(N);
    end
    m_pulse = adv;
    m_rd    = rd_next;
    @(posedge clk);
    #1;
    check("model_head",  32'(head_index),    32'(m_head));
    check("model_pulse", 32'(step_pulse),    32'(m_pulse));
    check("model_rdata", 32'(rd_if.r_data),  32'(m_rd));
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  task automatic read_px(input logic [31:0] p, input logic [15:0] exp, input string tag);
    rd_if.r_addr = p;
    tick();
    check(tag, 32'(rd_if.r_data), 32'(exp));
  endtask

  initial begin
    int cnt;
    int max_head;
    logic [15:0] cat_exp [5];
    logic [31:0] cat_p   [5];

    rd_if.r_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_head",  32'(head_index),   32'd0);
    check("reset_pulse", 32'(step_pulse),   32'd0);
    check("reset_rdata", 32'(rd_if.r_data), 32'd0);

    // First free-running advance lands on cycle 9 after release.
    nrst   = 1'b1;
    enable = 1'b1;
    repeat (7) tick();
    check("first_step_early", 32'(step_pulse), 32'd0);
    tick();
    check("first_step_pulse", 32'(step_pulse), 32'd1);
    check("first_step_head",  32'(head_index), 32'd1);

    // Caterpillar tail at head=1 wraps across pixel 0.
    cat_p   = '{32'd0, 32'd1, 32'd11, 32'd10, 32'd2};
    cat_exp = '{ON, ON, ON, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) read_px(cat_p[i], cat_exp[i], $sformatf("cat_p%0d", cat_p[i]));

    max_head = 1;
    for (int i = 0; i < 96 - 13; i++) begin
      tick();
      if (int'(head_index) > max_head) max_head = int'(head_index);
    end
    check("wrap12_head",     32'(head_index), 32'd0);
    check("wrap12_pulse",    32'(step_pulse), 32'd1);
    check("wrap12_max_head", 32'(max_head),   32'(N - 1));

    // Fill mode with manual stepping.
    mode   = MODE_FILL;
    enable = 1'b0;
    tick();
    check("fill_chg_head",  32'(head_index), 32'd0);
    check("fill_chg_pulse", 32'(step_pulse), 32'd0);
    cnt = 0;
    repeat (3) begin
      pulse_step();
      if (step_pulse) cnt++;
      tick();
      if (step_pulse) cnt++;
    end
    check("manual_pulses", 32'(cnt),        32'd3);
    check("manual_head",   32'(head_index), 32'd3);
    repeat (2) pulse_step();
    read_px(32'd5, ON,       "fill_p5");
    read_px(32'd6, 16'h0000, "fill_p6");
    repeat (7) pulse_step();
    check("fill_wrap_head", 32'(head_index), 32'd0);
    read_px(32'd0, ON,       "fill_wrap_p0");
    read_px(32'd1, 16'h0000, "fill_wrap_p1");

    // step_req held through a timer wrap must not add a second advance.
    enable   = 1'b1;
    step_req = 1'b1;
    cnt      = 0;
    repeat (STEP) begin
      tick();
      if (step_pulse) cnt++;
    end
    step_req = 1'b0;
    check("coincide_pulses", 32'(cnt),        32'd1);
    check("coincide_head",   32'(head_index), 32'd1);

    // Dot -> all-on mode change resets the head silently.
    mode   = MODE_DOT;
    enable = 1'b0;
    tick();
    repeat (7) pulse_step();
    check("dot_head7", 32'(head_index), 32'd7);
    mode = MODE_ALL_ON;
    tick();
    check("allon_chg_head",  32'(head_index), 32'd0);
    check("allon_chg_pulse", 32'(step_pulse), 32'd0);
    read_px(32'd12, 16'h0000, "allon_p12");
    read_px(32'd11, ON,       "allon_p11");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 3) != 0);
      step_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) mode = pattern_mode_t'($urandom_range(0, 3));
      rd_if.r_addr = 32'($urandom_range(0, 15));
      tick();
    end
    step_req = 1'b0;

    // Reset in the middle of a step period.
    enable = 1'b0;
    mode   = MODE_DOT;
    tick();
    mode = MODE_CATERPILLAR;
    tick();
    repeat (2) pulse_step();
    enable       = 1'b1;
    rd_if.r_addr = 32'd0;
    repeat (5) tick();
    check("pre_reset_head",  32'(head_index),   32'd2);
    check("pre_reset_rdata", 32'(rd_if.r_data), 32'(ON));
    nrst = 1'b0;
    #1;
    model_reset();
    check("midreset_head",  32'(head_index),   32'd0);
    check("midreset_pulse", 32'(step_pulse),   32'd0);
    check("midreset_rdata", 32'(rd_if.r_data), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (STEP - 1) tick();
    check("post_reset_early", 32'(step_pulse), 32'd0);
    tick();
    check("post_reset_pulse", 32'(step_pulse), 32'd1);
    check("post_reset_head",  32'(head_index), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter NB_COLS, 40, pixel columns per slice.
REQ-002 Parameter NB_ROWS, 48, pixel rows per slice; N = NB_COLS*NB_ROWS pixels.
REQ-003 Parameter DATA_W, 16, read-data width.
REQ-004 Parameter STEP_CYCLES, 40960, clk cycles per animation step (>=2).
REQ-005 Parameter TAIL_LEN, 4, lit length in caterpillar mode (1..N).
REQ-006 Parameter COLOR_ON, all-ones, value returned for a lit pixel.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 nrst  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  1 = free-running animation; 0 = frozen.
REQ-010 step_req  in  1  single-cycle pulse; advances one step when frozen.
REQ-011 mode  in  2  pattern select: 0 CATERPILLAR, 1 DOT, 2 FILL, 3 ALL_ON.
REQ-012 r_addr  in  32  flat pixel read address, p = row*NB_COLS + col.
REQ-013 r_data  out  DATA_W  pixel value for r_addr, RAM-like.
REQ-014 head_index  out  clog2(N)  current head pixel.
REQ-015 step_pulse  out  1  one-cycle pulse on every head advance.

Function
REQ-016 Step timer SHALL count 0..STEP_CYCLES-1 while enable=1, hold while enable=0; advance is generated on the cycle the count equals STEP_CYCLES-1, count then returns to 0.
REQ-017 With enable=0, step_req=1 SHALL generate exactly one advance that cycle; step_req SHALL be ignored while enable=1.
REQ-018 An advance SHALL set head_index to head_index+1, wrapping N-1 -> 0 (never reaching N), and SHALL assert step_pulse for exactly the following cycle.
REQ-019 Coincident timer wrap and step_req SHALL produce one advance only.
REQ-020 mode SHALL be registered; a change of registered mode SHALL reset head_index to 0 and step timer to 0 in the same cycle, with no step_pulse.
REQ-021 r_data SHALL be registered: valid 1 cycle after r_addr, computed from head_index and mode as of the r_addr cycle.
REQ-022 r_addr >= N SHALL return 0 in every mode.
REQ-023 CATERPILLAR: lit iff d < TAIL_LEN, d = (head_index - p) mod N computed without division (subtract, add N if negative); tail wraps across pixel 0.
REQ-024 DOT: lit iff p = head_index.
REQ-025 FILL: lit iff p <= head_index; wrap to 0 leaves only pixel 0 lit.
REQ-026 ALL_ON: every p < N lit; head still advances.
REQ-027 Lit pixels return COLOR_ON, unlit return 0.
REQ-028 No division or modulo by non-power-of-two constants on the read path; only compare/add/subtract.

Reset
REQ-029 On nrst low, immediately: timer 0, head_index 0, r_data 0, step_pulse 0, registered mode CATERPILLAR.
REQ-030 Reset mid-step SHALL discard the partial count; first advance after release occurs STEP_CYCLES cycles after release with enable=1.

Structure
REQ-031 Package test_pattern_pkg SHALL hold the pattern_mode_t enum (four values above) and defaults for NB_COLS, NB_ROWS, STEP_CYCLES.
REQ-032 Step timer and step_req arbitration SHALL be a sub-module step_timer (ports clk, nrst, enable, step_req, clear, advance).
REQ-033 All widths SHALL derive from parameters via clog2; no hard-coded 40/48.

Verification (NB_COLS=4, NB_ROWS=3, N=12, STEP_CYCLES=8, TAIL_LEN=3, COLOR_ON=16'hFFFF)
REQ-034 Reset release, enable=1 -> step_pulse first at cycle 9 after release, head_index=1; after 12 advances head_index=0, never 12.
REQ-035 CATERPILLAR at head=1, read p=0,1,11,10,2 -> FFFF,FFFF,FFFF,0,0, each 1 cycle after address.
REQ-036 FILL at head=5, read p=5,6 -> FFFF,0; advance to wrap, read p=0,1 -> FFFF,0.
REQ-037 enable=0 with step_req pulses x3 -> head +3, three step_pulses; enable=1 with step_req on wrap cycle -> single advance.
REQ-038 Mode change DOT->ALL_ON at head=7 -> head_index=0 next cycle, no step_pulse; read p=12 -> 0, p=11 -> FFFF.
REQ-039 nrst asserted mid-step at timer=5 -> all outputs 0 immediately; next advance exactly 8 cycles after release.
